lif_neuron_layer1: RTL and testbench
====================================

# lif_neuron_layer1

Leaky integrate-and-fire neuron stage that sits directly downstream of the layer-1 biased MAC. Each valid cycle, the MAC's signed 8-bit biased sum is taken as input current and integrated into a saturating signed membrane potential with optional leak. The block fires a one-cycle spike on a threshold crossing, then holds a refractory period. It keeps a per-window spike count that the layer-2 and classification logic consume.

## Interface
Parameters:
- `VW`, 16: membrane potential width (signed).
- `THRESH`, 100: firing threshold (signed, `VW` bits); fire when `v_next >= THRESH`.
- `V_RESET`, 0: potential loaded after a spike.
- `LEAK_SHIFT`, 3: leak = `v >>> LEAK_SHIFT`; only used when the leak is compiled in.
- `REFRAC`, 2: number of valid inputs ignored after a spike; 0 means no refractory period.
- `CW`, 8: spike counter width.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `current`, in, 8: signed input current (the MAC `final_out`).
- `in_valid`, in, 1: `current` is valid this cycle.
- `clear`, in, 1: synchronous start-of-window clear.
- `spike`, out, 1: neuron fired on this output sample.
- `out_valid`, out, 1: `spike` and `membrane` are valid this cycle.
- `membrane`, out, `VW`: current potential.
- `refractory`, out, 1: neuron is in the REFRACTORY state.
- `spike_count`, out, `CW`: spikes since last `clear` or `rst`, saturating.

## Operation
- States:
  - INTEGRATE (reset state).
  - REFRACTORY, with a refractory counter `rc`.
- INTEGRATE, on `in_valid`:
  - Compute `v_next = sat(v - leak + sext(current))` at `VW+2` bits.
  - `leak = v >>> LEAK_SHIFT` (arithmetic shift) when the leak is compiled in, else 0.
  - Saturate to [-2^(VW-1), 2^(VW-1)-1].
- If `v_next >= THRESH`:
  - `spike=1` and `v <= V_RESET`.
  - `spike_count` increments, saturating at 2^CW-1.
  - If `REFRAC>0`: `rc <= REFRAC` and go to REFRACTORY.
- Otherwise `v <= v_next` and `spike=0`.
- REFRACTORY, on `in_valid`:
  - `current` is discarded, `v` stays `V_RESET`, no leak is applied, `spike=0`.
  - `rc` decrements; at `rc==1` return to INTEGRATE.
- No `in_valid`: all state holds; `out_valid=0`, `spike=0`.
- `clear` has priority over everything, including a simultaneous `in_valid`, whose input is dropped:
  - `v <= 0`, `spike_count <= 0`, `rc <= 0`, state <= INTEGRATE.
  - `out_valid=0` and `spike=0` next cycle.
- `rst` (asynchronous), at any time including mid-refractory: same effect as `clear`.
- Reset values:
  - `spike`=0, `out_valid`=0, `membrane`=0, `refractory`=0, `spike_count`=0.

## Timing
- Latency is 1 cycle. `in_valid` at edge N gives registered `spike`, `out_valid` and `membrane` after edge N.
- `out_valid` is exactly `in_valid` delayed one cycle, except it is forced to 0 by `clear` or `rst`.
- `spike` is a one-cycle pulse and is only ever high together with `out_valid`.
- Throughput: one input per cycle, with no backpressure (there is no ready signal).
- `refractory` is registered and reflects the state after the same edge.
- Back-to-back inputs during REFRACTORY each consume exactly one `rc` count.

## Configuration
- `LIF_LEAK_EN` defined: the leak term `v >>> LEAK_SHIFT` is subtracted on every integrating input (LIF).
- `LIF_LEAK_EN` undefined: the leak term is 0 and the shift logic is not built; the block is a pure integrate-and-fire neuron.
- Unless a scenario states otherwise, the test plan uses the default parameters with `LIF_LEAK_EN` defined.

## Test plan
- **Leak accumulation:** `current=30` on 4 consecutive valid cycles.
  - With `LIF_LEAK_EN`: `membrane` = 30, 57, 80, then `spike=1` on the 4th input (`v_next=100`) and `membrane=0`.
  - Without `LIF_LEAK_EN`: 30, 60, 90, then spike on the 4th input (120).
- **Refractory:** after that spike, apply `current=127` three times.
  - Inputs 1–2: `spike=0`, `membrane=0`, `refractory=1`.
  - Input 3: `spike=1` (127 ≥ 100), `spike_count=2`.
- **Saturation:** with `LIF_LEAK_EN` undefined, apply `current=-128` for 257 valid cycles.
  - After input 256, `membrane=-32768`; it stays -32768 on input 257.
  - No spike and no wrap at any point.
- **Clear priority:** at `v=80`, assert `clear` together with `in_valid` and `current=50`.
  - Next cycle: `out_valid=0`, `membrane=0`, `spike_count=0`.
  - A following `current=30` gives `membrane=30`.
- **Counter saturation:** with `REFRAC=0`, apply `current=127` for 300 cycles.
  - Every output has `spike=1`.
  - `spike_count` reaches 255 and holds at 255.
- **Async reset mid-refractory:** pulse `rst` between clock edges while `refractory=1`.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - The first input after release integrates normally.

Source files
------------

// File: rtl/lif_neuron_layer1_if.sv
// Input-current and neuron-output bundle for lif_neuron_layer1.
// master drives current/in_valid/clear; slave is the neuron.
interface lif_neuron_layer1_if #(
   parameter int VW = 16,
   parameter int CW = 8
);
   logic signed [7:0]    current;
   logic                 in_valid;
   logic                 clear;
   logic                 spike;
   logic                 out_valid;
   logic signed [VW-1:0] membrane;
   logic                 refractory;
   logic [CW-1:0]        spike_count;

   modport master (
      output current, in_valid, clear,
      input  spike, out_valid, membrane, refractory, spike_count
   );

   modport slave (
      input  current, in_valid, clear,
      output spike, out_valid, membrane, refractory, spike_count
   );
endinterface

// File: rtl/lif_neuron_layer1.sv
// Leaky integrate-and-fire neuron fed by the layer-1 biased MAC.
// Define LIF_LEAK_EN to build the v >>> LEAK_SHIFT leak term.
module lif_neuron_layer1 #(
   parameter int                 VW         = 16,
   parameter logic signed [VW-1:0] THRESH   = 100,
   parameter logic signed [VW-1:0] V_RESET  = 0,
   parameter int                 LEAK_SHIFT = 3,
   parameter int                 REFRAC     = 2,
   parameter int                 CW         = 8
) (
   input logic clk,
   input logic rst,
   lif_neuron_layer1_if.slave bus
);
   typedef enum logic {INTEGRATE, REFRACTORY} state_t;

   localparam int RCW = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;
   localparam int SW  = VW + 2;
   localparam logic signed [SW-1:0] VMAX = {3'b000, {(VW-1){1'b1}}};
   localparam logic signed [SW-1:0] VMIN = {3'b111, {(VW-1){1'b0}}};

   state_t               state, state_n;
   logic signed [VW-1:0] v, v_n;
   logic [RCW-1:0]       rc, rc_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic                 spike_q, spike_n;
   logic                 ov_q, ov_n;

   logic signed [SW-1:0] v_ext, cur_ext, leak, sum;
   logic signed [VW-1:0] v_sat;
   logic                 fire;

   assign v_ext   = $signed({{2{v[VW-1]}}, v});
   assign cur_ext = $signed({{(SW-8){bus.current[7]}}, bus.current});

`ifdef LIF_LEAK_EN
   assign leak = v_ext >>> LEAK_SHIFT;
`else
   assign leak = '0;
`endif

   assign sum = v_ext - leak + cur_ext;

   always_comb begin
      v_sat = sum[VW-1:0];
      if (sum > VMAX)
         v_sat = VMAX[VW-1:0];
      else if (sum < VMIN)
         v_sat = VMIN[VW-1:0];
   end

   assign fire = (v_sat >= THRESH);

   always_comb begin
      state_n = state;
      v_n     = v;
      rc_n    = rc;
      cnt_n   = cnt;
      spike_n = 1'b0;
      ov_n    = 1'b0;
      if (bus.clear) begin
         state_n = INTEGRATE;
         v_n     = '0;
         rc_n    = '0;
         cnt_n   = '0;
      end else if (bus.in_valid) begin
         ov_n = 1'b1;
         unique case (state)
            INTEGRATE: begin
               if (fire) begin
                  spike_n = 1'b1;
                  v_n     = V_RESET;
                  if (cnt != {CW{1'b1}})
                     cnt_n = cnt + 1'b1;
                  if (REFRAC > 0) begin
                     rc_n    = RCW'(REFRAC);
                     state_n = REFRACTORY;
                  end
               end else begin
                  v_n = v_sat;
               end
            end
            REFRACTORY: begin
               // input dropped, no leak while refractory
               v_n  = V_RESET;
               rc_n = rc - 1'b1;
               if (rc <= RCW'(1))
                  state_n = INTEGRATE;
            end
            default: state_n = INTEGRATE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= INTEGRATE;
         v       <= '0;
         rc      <= '0;
         cnt     <= '0;
         spike_q <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state   <= state_n;
         v       <= v_n;
         rc      <= rc_n;
         cnt     <= cnt_n;
         spike_q <= spike_n;
         ov_q    <= ov_n;
      end
   end

   assign bus.spike       = spike_q;
   assign bus.out_valid   = ov_q;
   assign bus.membrane    = v;
   assign bus.refractory  = (state == REFRACTORY);
   assign bus.spike_count = cnt;
endmodule

// File: tb/tb_lif_neuron_layer1.sv
// Directed + random bench for lif_neuron_layer1 against a
// behavioural neuron model (default DUT and a REFRAC=0 DUT).
module tb_lif_neuron_layer1;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   lif_neuron_layer1_if #(.VW(16), .CW(8)) b0 ();
   lif_neuron_layer1_if #(.VW(16), .CW(8)) b1 ();

   lif_neuron_layer1 u_dut (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   lif_neuron_layer1 #(.REFRAC(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   // reference model state, index 0 = REFRAC 2, 1 = REFRAC 0
   int m_v[2], m_rem[2], m_cnt[2];
   bit m_ov[2], m_sp[2];
   int refrac_of[2] = '{2, 0};

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_v[n] = 0; m_rem[n] = 0; m_cnt[n] = 0;
         m_ov[n] = 0; m_sp[n] = 0;
      end
   endtask

   task automatic model_step(input bit iv, input bit clr, input int cur);
      int leak, nx;
      for (int n = 0; n < 2; n++) begin
         m_ov[n] = 0;
         m_sp[n] = 0;
         if (clr) begin
            m_v[n] = 0; m_rem[n] = 0; m_cnt[n] = 0;
         end else if (iv) begin
            m_ov[n] = 1;
            if (m_rem[n] > 0) begin
               m_rem[n]--;
               m_v[n] = 0;
            end else begin
`ifdef LIF_LEAK_EN
               leak = m_v[n] >>> 3;
`else
               leak = 0;
`endif
               nx = m_v[n] - leak + cur;
               if (nx > 32767) nx = 32767;
               if (nx < -32768) nx = -32768;
               if (nx >= 100) begin
                  m_sp[n] = 1;
                  m_v[n] = 0;
                  if (m_cnt[n] < 255) m_cnt[n]++;
                  m_rem[n] = refrac_of[n];
               end else begin
                  m_v[n] = nx;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("d0_ov",   b0.out_valid,   m_ov[0]);
      chk("d0_sp",   b0.spike,       m_sp[0]);
      chk("d0_mem",  b0.membrane,    m_v[0]);
      chk("d0_ref",  b0.refractory,  m_rem[0] > 0);
      chk("d0_cnt",  b0.spike_count, m_cnt[0]);
      chk("d1_ov",   b1.out_valid,   m_ov[1]);
      chk("d1_sp",   b1.spike,       m_sp[1]);
      chk("d1_mem",  b1.membrane,    m_v[1]);
      chk("d1_ref",  b1.refractory,  0);
      chk("d1_cnt",  b1.spike_count, m_cnt[1]);
   endtask

   task automatic step(input bit iv, input bit clr, input int cur);
      b0.in_valid = iv; b1.in_valid = iv;
      b0.clear    = clr; b1.clear   = clr;
      b0.current  = 8'(cur); b1.current = 8'(cur);
      @(posedge clk);
      #1;
      model_step(iv, clr, cur);
      check_all();
   endtask

   int exp_m[4];
   int pre[4];

   initial begin
      rst = 1'b1;
      b0.in_valid = 0; b0.clear = 0; b0.current = 0;
      b1.in_valid = 0; b1.clear = 0; b1.current = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk) rst = 1'b0;

      // leak accumulation
`ifdef LIF_LEAK_EN
      exp_m = '{30, 57, 80, 0};
`else
      exp_m = '{30, 60, 90, 0};
`endif
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 30);
         chk("acc_mem", b0.membrane, exp_m[i]);
         chk("acc_spk", b0.spike, i == 3);
      end

      // refractory
      for (int i = 0; i < 3; i++) begin
         chk("ref_pre", b0.refractory, i < 2);
         step(1, 0, 127);
         chk("ref_spk", b0.spike, i == 2);
         chk("ref_mem", b0.membrane, 0);
      end
      chk("ref_cnt", b0.spike_count, 2);

      // negative saturation
      step(0, 1, 0);
      for (int i = 0; i < 257; i++) begin
         step(1, 0, -128);
         chk("sat_spk", b0.spike, 0);
`ifndef LIF_LEAK_EN
         if (i >= 255) chk("sat_mem", b0.membrane, -32768);
`endif
      end

      // clear beats a simultaneous valid input
      step(0, 1, 0);
`ifdef LIF_LEAK_EN
      pre = '{30, 30, 30, 0};
`else
      pre = '{30, 30, 20, 0};
`endif
      for (int i = 0; i < 3; i++) step(1, 0, pre[i]);
      chk("clr_pre", b0.membrane, 80);
      step(1, 1, 50);
      chk("clr_ov",  b0.out_valid, 0);
      chk("clr_mem", b0.membrane, 0);
      chk("clr_cnt", b0.spike_count, 0);
      step(1, 0, 30);
      chk("clr_post", b0.membrane, 30);

      // spike counter saturation on REFRAC=0
      step(0, 1, 0);
      for (int i = 0; i < 300; i++) begin
         step(1, 0, 127);
         chk("cs_spk", b1.spike, 1);
      end
      chk("cs_cnt", b1.spike_count, 255);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, ($urandom % 25) == 0,
              int'($urandom_range(0, 255)) - 128);

      // async reset mid-refractory
      step(0, 1, 0);
      step(1, 0, 127);
      chk("ar_pre", b0.refractory, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      chk("ar_ov",  b0.out_valid, 0);
      chk("ar_spk", b0.spike, 0);
      chk("ar_mem", b0.membrane, 0);
      chk("ar_ref", b0.refractory, 0);
      chk("ar_cnt", b0.spike_count, 0);
      #2;
      rst = 1'b0;
      step(1, 0, 30);
      chk("ar_post", b0.membrane, 30);
      chk("ar_post_ref", b0.refractory, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
